// File: rtl/reg_file_param.sv
// reg_file_param: 2-read/1-write register file with optional hardwired zero register and a sequential clear engine.
// Optional feature: define REGFILE_BYPASS_EN for write-first read bypass (default build is read-first).
`default_nettype none

module reg_file_param #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic [DATA_W-1:0]   rd_data1_q, rd_data1_d;
  logic [DATA_W-1:0]   rd_data2_q, rd_data2_d;
  logic                wr_commit;
  logic                wr_is_zero;

  assign wr_ready   = (state_q != CLEAR);
  assign clr_busy   = (state_q == CLEAR);
  assign clr_done   = (state_q == DONE);
  assign rd_data1   = rd_data1_q;
  assign rd_data2   = rd_data2_q;
  assign wr_commit  = wr_en && wr_ready;
  assign wr_is_zero = ZERO_REG && (wr_addr == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE:    if (clr_req) state_d = CLEAR;
      CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (state_q == CLEAR) begin
      mem_d[cnt_q] = '0;
    end else if (wr_commit && !wr_is_zero) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Read data is sampled from the array state before this edge's write/clear takes effect.
  always_comb begin
    rd_data1_d = mem_q[rd_addr1];
    rd_data2_d = mem_q[rd_addr2];
`ifdef REGFILE_BYPASS_EN
    if (wr_commit && !wr_is_zero && (wr_addr == rd_addr1)) rd_data1_d = wr_data;
    if (wr_commit && !wr_is_zero && (wr_addr == rd_addr2)) rd_data2_d = wr_data;
`endif
    if (ZERO_REG && (rd_addr1 == '0)) rd_data1_d = '0;
    if (ZERO_REG && (rd_addr2 == '0)) rd_data2_d = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mem_q      <= '{default: '0};
      rd_data1_q <= '0;
      rd_data2_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_q      <= mem_d;
      rd_data1_q <= rd_data1_d;
      rd_data2_q <= rd_data2_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: directed self-checking bench for reg_file_param (default parameters).
`default_nettype none

module tb_reg_file_param;

  logic        clock;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic [3:0]  rd_addr1, rd_addr2;
  logic [15:0] rd_data1, rd_data2;
  logic        clr_req;
  logic        clr_busy;
  logic        clr_done;

  int total;
  int bad;

  reg_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b1)) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n;
    logic [15:0] exp31;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr1 = 4'd1; rd_addr2 = 4'd2; clr_req = 1'b0;

    #3;
    check("rst_rd1", 32'(rd_data1), 32'h0);
    check("rst_rd2", 32'(rd_data2), 32'h0);
    check("rst_wr_ready", 32'(wr_ready), 32'h1);
    check("rst_busy", 32'(clr_busy), 32'h0);
    check("rst_done", 32'(clr_done), 32'h0);
    #9 reset = 1'b1;
    tick();

    // basic write then read
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 16'h7B18;
    tick();
    wr_en = 1'b0; rd_addr1 = 4'd1;
    tick();
    check("rd_addr1", 32'(rd_data1), 32'h7B18);

    // zero register
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
    tick();
    wr_en = 1'b0; rd_addr1 = 4'd0; rd_addr2 = 4'd0;
    tick();
    check("zero_rd1", 32'(rd_data1), 32'h0);
    check("zero_rd2", 32'(rd_data2), 32'h0);

    // same-edge write/read
`ifdef REGFILE_BYPASS_EN
    exp31 = 16'h246B;
`else
    exp31 = 16'h0000;
`endif
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h246B; rd_addr1 = 4'd3;
    tick();
    check("same_edge_rd", 32'(rd_data1), 32'(exp31));
    wr_en = 1'b0;
    tick();
    check("next_rd", 32'(rd_data1), 32'h246B);

    // independent ports, and same address on both
    rd_addr1 = 4'd1; rd_addr2 = 4'd3;
    tick();
    check("indep_rd1", 32'(rd_data1), 32'h7B18);
    check("indep_rd2", 32'(rd_data2), 32'h246B);
    rd_addr1 = 4'd3; rd_addr2 = 4'd3;
    tick();
    check("same_addr_rd1", 32'(rd_data1), 32'h246B);
    check("same_addr_rd2", 32'(rd_data2), 32'h246B);

    // fill 1..15
    for (int a = 1; a < 16; a++) begin
      wr_en = 1'b1; wr_addr = 4'(a); wr_data = 16'hA5A5;
      tick();
    end
    wr_en = 1'b0; rd_addr1 = 4'd15; rd_addr2 = 4'd5;
    tick();
    check("fill_rd15", 32'(rd_data1), 32'hA5A5);
    check("fill_rd5", 32'(rd_data2), 32'hA5A5);

    // full clear
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!clr_busy) break;
      check("clr_wr_ready", 32'(wr_ready), 32'h0);
      check("clr_no_done", 32'(clr_done), 32'h0);
      if (n == 4) begin rd_addr1 = 4'd2; rd_addr2 = 4'd15; end
      if (n == 5) begin
        check("clr_mid_rd2", 32'(rd_data1), 32'h0);
        check("clr_mid_rd15", 32'(rd_data2), 32'hA5A5);
      end
      wr_en = (n == 10); wr_addr = 4'd5; wr_data = 16'h0051;
      n++;
      tick();
    end
    wr_en = 1'b0;
    check("clr_busy_cycles", 32'(n), 32'd16);
    check("clr_done_pulse", 32'(clr_done), 32'h1);
    check("done_wr_ready", 32'(wr_ready), 32'h1);
    rd_addr1 = 4'd5; rd_addr2 = 4'd15;
    tick();
    check("done_one_cycle", 32'(clr_done), 32'h0);
    check("post_clr_rd5", 32'(rd_data1), 32'h0);
    check("post_clr_rd15", 32'(rd_data2), 32'h0);

    // reset mid-clear
    wr_en = 1'b1; wr_addr = 4'd12; wr_data = 16'h1234; rd_addr1 = 4'd12;
    tick();
    wr_en = 1'b0;
    tick();
    check("pre_abort_rd12", 32'(rd_data1), 32'h1234);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("abort_busy_before", 32'(clr_busy), 32'h1);
    check("abort_rd12_before", 32'(rd_data1), 32'h1234);
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(clr_busy), 32'h0);
    check("abort_wr_ready", 32'(wr_ready), 32'h1);
    check("abort_rd1", 32'(rd_data1), 32'h0);
    check("abort_done", 32'(clr_done), 32'h0);
    #2 reset = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (clr_done || clr_busy) n++;
    end
    check("abort_no_done", 32'(n), 32'h0);
    check("abort_ready_after", 32'(wr_ready), 32'h1);
    check("abort_rd12_after", 32'(rd_data1), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
